// File: rtl/elevator_pkg.sv
// Elevator controller shared definitions.
// Car command encodings, FSM state type and default floor count.
package elevator_pkg;
  localparam int NUM_FLOORS_DEF = 5;

  localparam logic [1:0] CMD_STOP = 2'b00;
  localparam logic [1:0] CMD_DOWN = 2'b10;
  localparam logic [1:0] CMD_UP   = 2'b11;

  typedef enum logic [2:0] {
    FSM_IDLE,
    FSM_STEP,
    FSM_SETTLE,
    FSM_DOOR,
    FSM_FAULT
  } fsm_e;
endpackage

// File: rtl/elev_req_sched.sv
// Pending-call register with above/below/at-floor reductions.
// Out-of-range floor_cur yields no at-floor match.
module elev_req_sched
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = NUM_FLOORS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [4:0]            floor_cur,
  input  logic                  clr_cur,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  any_above,
  output logic                  any_below,
  output logic                  at_floor,
  output logic                  call_here
);
  logic [NUM_FLOORS-1:0] pending_q, pending_d;

  always_comb begin
    pending_d = pending_q | call_btn;
    any_above = 1'b0;
    any_below = 1'b0;
    at_floor  = 1'b0;
    call_here = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (int'(floor_cur) == i) begin
        at_floor  = pending_q[i];
        call_here = call_btn[i];
        // clearing also swallows a call arriving on the same edge
        if (clr_cur) pending_d[i] = 1'b0;
      end
      if (i > int'(floor_cur)) any_above = any_above | pending_q[i];
      if (i < int'(floor_cur)) any_below = any_below | pending_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign pending = pending_q;
endmodule

// File: rtl/elevator_ctrl.sv
// SCAN elevator controller: step/settle/door FSM with sticky fault.
// All outputs are registered; the scheduler owns the pending calls.
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS    = NUM_FLOORS_DEF,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [4:0]            floor_cur,
  output logic [1:0]            state,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  door_open,
  output logic                  fault
);
  // the IDLE re-evaluation cycle is the last of the travel stop cycles
  localparam logic [7:0] SETTLE_LOAD = 8'(TRAVEL_CYCLES - 2);
  localparam logic [7:0] DOOR_LOAD   = 8'(DOOR_CYCLES - 1);

  fsm_e       fsm_q, fsm_d;
  logic [7:0] cnt_q, cnt_d;
  logic       dir_up_q, dir_up_d;
  logic [1:0] state_q, state_d;
  logic       door_q, door_d;
  logic       fault_q, fault_d;

  logic clr_cur, any_above, any_below, at_floor, call_here;
  logic bad_floor, top_floor, bot_floor, go_up, go_down;

  elev_req_sched #(
    .NUM_FLOORS(NUM_FLOORS)
  ) u_sched (
    .clk      (clk),
    .rst_n    (rst_n),
    .call_btn (call_btn),
    .floor_cur(floor_cur),
    .clr_cur  (clr_cur),
    .pending  (pending),
    .any_above(any_above),
    .any_below(any_below),
    .at_floor (at_floor),
    .call_here(call_here)
  );

  assign bad_floor = int'(floor_cur) >= NUM_FLOORS;
  assign top_floor = int'(floor_cur) == NUM_FLOORS - 1;
  assign bot_floor = floor_cur == 5'd0;

  always_comb begin
    go_up   = dir_up_q ? any_above : (any_above && !any_below);
    go_down = dir_up_q ? (any_below && !any_above) : any_below;
  end

  always_comb begin
    fsm_d    = fsm_q;
    cnt_d    = cnt_q;
    dir_up_d = dir_up_q;
    state_d  = CMD_STOP;
    door_d   = 1'b0;
    fault_d  = fault_q;
    clr_cur  = 1'b0;
    if (bad_floor || fsm_q == FSM_FAULT) begin
      fsm_d   = FSM_FAULT;
      fault_d = 1'b1;
    end else begin
      unique case (fsm_q)
        FSM_IDLE: begin
          if (at_floor) begin
            fsm_d   = FSM_DOOR;
            cnt_d   = DOOR_LOAD;
            door_d  = 1'b1;
            clr_cur = 1'b1;
          end else if (go_up && !top_floor) begin
            fsm_d    = FSM_STEP;
            dir_up_d = 1'b1;
            state_d  = CMD_UP;
          end else if (go_down && !bot_floor) begin
            fsm_d    = FSM_STEP;
            dir_up_d = 1'b0;
            state_d  = CMD_DOWN;
          end
        end
        FSM_STEP: begin
          fsm_d = FSM_SETTLE;
          cnt_d = SETTLE_LOAD;
        end
        FSM_SETTLE: begin
          if (cnt_q == 8'd0) fsm_d = FSM_IDLE;
          else               cnt_d = cnt_q - 8'd1;
        end
        FSM_DOOR: begin
          clr_cur = 1'b1;
          door_d  = 1'b1;
          if (call_here) begin
            cnt_d = DOOR_LOAD;
          end else if (cnt_q == 8'd0) begin
            fsm_d  = FSM_IDLE;
            door_d = 1'b0;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        FSM_FAULT: fault_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= FSM_IDLE;
      cnt_q    <= 8'd0;
      dir_up_q <= 1'b1;
      state_q  <= CMD_STOP;
      door_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      cnt_q    <= cnt_d;
      dir_up_q <= dir_up_d;
      state_q  <= state_d;
      door_q   <= door_d;
      fault_q  <= fault_d;
    end
  end

  assign state     = state_q;
  assign door_open = door_q;
  assign fault     = fault_q;
endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl with a closed-loop car model.
// Expected {state,door_open} traces are hand-derived per cycle.
module tb_elevator_ctrl;
  import elevator_pkg::*;

  localparam int NF = 5;
  localparam logic [2:0] E_UP   = 3'b110;
  localparam logic [2:0] E_DN   = 3'b100;
  localparam logic [2:0] E_STOP = 3'b000;
  localparam logic [2:0] E_DOOR = 3'b001;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NF-1:0] call_btn = '0;
  logic [4:0]    floor_cur;
  logic [1:0]    state;
  logic [NF-1:0] pending;
  logic          door_open;
  logic          fault;

  logic [4:0] pos = 5'd0;
  logic       load_req = 1'b0;
  logic [4:0] load_val = 5'd0;
  logic       force7 = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2:0] exp_q[$];

  elevator_ctrl #(
    .NUM_FLOORS   (NF),
    .TRAVEL_CYCLES(4),
    .DOOR_CYCLES  (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .call_btn (call_btn),
    .floor_cur(floor_cur),
    .state    (state),
    .pending  (pending),
    .door_open(door_open),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  assign floor_cur = force7 ? 5'd7 : pos;

  always @(posedge clk) begin
    if (load_req)              pos <= load_val;
    else if (state == CMD_UP)   pos <= pos + 5'd1;
    else if (state == CMD_DOWN) pos <= pos - 5'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [2:0] v, input int n);
    repeat (n) exp_q.push_back(v);
  endtask

  task automatic run_seq(input string tag);
    int k;
    logic [2:0] e;
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("%s[%0d]", tag, k), 32'({state, door_open}), 32'(e));
      k++;
    end
  endtask

  task automatic reset_to(input logic [4:0] p);
    @(negedge clk);
    rst_n    = 1'b0;
    call_btn = '0;
    force7   = 1'b0;
    load_req = 1'b1;
    load_val = p;
    @(negedge clk);
    load_req = 1'b0;
    chk("rst_state", 32'(state), 32'(CMD_STOP));
    chk("rst_pend", 32'(pending), 32'd0);
    chk("rst_door", 32'(door_open), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    // one call two floors up from idle at floor 0
    reset_to(5'd0);
    call_btn = 5'b00100;
    @(negedge clk);
    call_btn = '0;
    chk("t32_pend", 32'(pending), 32'b00100);
    chk("t32_lat", 32'(state), 32'(CMD_STOP));
    push(E_UP, 1); push(E_STOP, 4);
    push(E_UP, 1); push(E_STOP, 4);
    push(E_DOOR, 8); push(E_STOP, 1);
    run_seq("t32");
    chk("t32_clr", 32'(pending), 32'd0);
    chk("t32_floor", 32'(floor_cur), 32'd2);

    // at 2 heading up: serve 4 first, then reverse to 0
    call_btn = 5'b10001;
    @(negedge clk);
    call_btn = '0;
    chk("t33_pend", 32'(pending), 32'b10001);
    push(E_UP, 1); push(E_STOP, 4);
    push(E_UP, 1); push(E_STOP, 4);
    push(E_DOOR, 8); push(E_STOP, 1);
    repeat (4) begin
      push(E_DN, 1); push(E_STOP, 4);
    end
    push(E_DOOR, 8); push(E_STOP, 1);
    run_seq("t33");
    chk("t33_clr", 32'(pending), 32'd0);
    chk("t33_floor", 32'(floor_cur), 32'd0);

    // call at the top floor opens the door; repeat call restarts dwell
    reset_to(5'd4);
    call_btn = 5'b10000;
    @(negedge clk);
    call_btn = '0;
    chk("t34_pend", 32'(pending), 32'b10000);
    chk("t34_lat", 32'(state), 32'(CMD_STOP));
    push(E_DOOR, 3);
    run_seq("t34a");
    chk("t34_clr", 32'(pending), 32'd0);
    call_btn = 5'b10000;
    @(negedge clk);
    call_btn = '0;
    chk("t34_abs", 32'(pending), 32'd0);
    chk("t34_rst", 32'({state, door_open}), 32'(E_DOOR));
    push(E_DOOR, 7); push(E_STOP, 2);
    run_seq("t34b");
    chk("t34_floor", 32'(floor_cur), 32'd4);

    // asynchronous reset mid-STEP
    reset_to(5'd0);
    call_btn = 5'b01010;
    @(negedge clk);
    call_btn = '0;
    @(negedge clk);
    chk("t35_step", 32'(state), 32'(CMD_UP));
    #1 rst_n = 1'b0;
    #1 chk("t35_async_st", 32'(state), 32'(CMD_STOP));
    chk("t35_async_pd", 32'(pending), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // asynchronous reset mid-SETTLE
    call_btn = 5'b01010;
    @(negedge clk);
    call_btn = '0;
    @(negedge clk);
    @(negedge clk);
    chk("t35_pend", 32'(pending), 32'b01010);
    #1 rst_n = 1'b0;
    #1 chk("t35_settle_st", 32'(state), 32'(CMD_STOP));
    chk("t35_settle_pd", 32'(pending), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("t35_idle[%0d]", i), 32'(state), 32'(CMD_STOP));
    end
    chk("t35_idle_pd", 32'(pending), 32'd0);

    // out-of-range floor: sticky fault, calls still latch
    reset_to(5'd1);
    force7 = 1'b1;
    @(negedge clk);
    chk("t36_fault", 32'(fault), 32'd1);
    chk("t36_state", 32'(state), 32'(CMD_STOP));
    call_btn = 5'b00100;
    @(negedge clk);
    call_btn = '0;
    force7 = 1'b0;
    chk("t36_pend", 32'(pending), 32'b00100);
    repeat (8) @(negedge clk);
    chk("t36_sticky", 32'(fault), 32'd1);
    chk("t36_hold", 32'(state), 32'(CMD_STOP));
    chk("t36_frozen", 32'(pending), 32'b00100);
    chk("t36_door", 32'(door_open), 32'd0);
    rst_n = 1'b0;
    #1 chk("t36_clr", 32'(fault), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
